// File: rtl/q_action_select.sv
// q_action_select: scans the four Q values of a 6x6 maze state and emits the legal argmax.
// Define Q_SEL_EPSILON_EN to add LFSR-driven epsilon-greedy exploration at DONE.
module q_action_select #(
  parameter int         Q_W        = 32,
  parameter logic [7:0] EPS_THRESH = 8'd26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [5:0]     maze_state,
  input  logic [3:0]     blocked_mask,
  output logic           q_rd_en,
  output logic [5:0]     q_rd_state,
  output logic [1:0]     q_rd_action,
  input  logic [Q_W-1:0] q_rd_data,
  output logic [3:0]     action,
  output logic           action_valid,
  output logic           no_legal,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DONE, ERR} state_t;

  state_t                state;
  logic [3:0]            legal, legal_in;
  logic                  s_bad;
  logic                  have_best, nxt_have, cmp_en, take;
  logic [1:0]            best_idx, nxt_idx, cmp_idx, pick, explore_idx, j;
  logic signed [Q_W-1:0] best_val;
  logic [9:0]            rnd;

  always_comb begin
    s_bad       = (maze_state == 6'd0) || (maze_state > 6'd36);
    legal_in[0] = !blocked_mask[0] && (maze_state <= 6'd30);
    legal_in[1] = !blocked_mask[1] && ((maze_state % 6'd6) != 6'd0);
    legal_in[2] = !blocked_mask[2] && (maze_state >= 6'd7);
    legal_in[3] = !blocked_mask[3] && ((maze_state % 6'd6) != 6'd1);
  end

  // Read data trails the strobe by one cycle, so SCAN k judges action k-1 and DRAIN judges action 3.
  always_comb begin
    cmp_en   = ((state == SCAN) && (q_rd_action != 2'd0)) || (state == DRAIN);
    cmp_idx  = (state == DRAIN) ? 2'd3 : q_rd_action - 2'd1;
    take     = cmp_en && legal[cmp_idx] && (!have_best || ($signed(q_rd_data) > best_val));
    nxt_have = have_best | take;
    nxt_idx  = take ? cmp_idx : best_idx;
  end

`ifdef Q_SEL_EPSILON_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rnd = lfsr[9:0];
`else
  // All-ones can never fall below an 8-bit threshold, so the explore path folds away.
  assign rnd = 10'h3FF;
`endif

  always_comb begin
    j           = 2'd0;
    explore_idx = nxt_idx;
    for (int i = 3; i >= 0; i--) begin
      j = rnd[9:8] + 2'(i);
      if (legal[j]) explore_idx = j;
    end
    pick = ((rnd[7:0] < EPS_THRESH) && nxt_have) ? explore_idx : nxt_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      legal        <= 4'd0;
      have_best    <= 1'b0;
      best_idx     <= 2'd0;
      best_val     <= '0;
      q_rd_en      <= 1'b0;
      q_rd_state   <= 6'd0;
      q_rd_action  <= 2'd0;
      action       <= 4'hF;
      action_valid <= 1'b0;
      no_legal     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy      <= 1'b1;
          have_best <= 1'b0;
          best_idx  <= 2'd0;
          if (s_bad) begin
            state        <= ERR;
            action       <= 4'hF;
            no_legal     <= 1'b1;
            action_valid <= 1'b1;
          end else begin
            state       <= SCAN;
            legal       <= legal_in;
            q_rd_state  <= maze_state;
            q_rd_action <= 2'd0;
            q_rd_en     <= 1'b1;
          end
        end
        SCAN: begin
          have_best <= nxt_have;
          best_idx  <= nxt_idx;
          if (take) best_val <= $signed(q_rd_data);
          if (q_rd_action == 2'd3) begin
            q_rd_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            q_rd_action <= q_rd_action + 2'd1;
          end
        end
        DRAIN: begin
          have_best    <= nxt_have;
          best_idx     <= nxt_idx;
          if (take) best_val <= $signed(q_rd_data);
          action       <= nxt_have ? {2'b00, pick} : 4'hF;
          no_legal     <= !nxt_have;
          action_valid <= 1'b1;
          state        <= DONE;
        end
        DONE, ERR: begin
          action_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_action_select.sv
// Bench for q_action_select: Q-table model, scoreboard of expected results, per-scenario tasks.
// Define Q_SEL_EPSILON_EN to run the exploration-legality scenario instead of the greedy ones.
module tb_q_action_select;
  localparam int Q_W = 32;
`ifdef Q_SEL_EPSILON_EN
  localparam logic [7:0] EPS = 8'd255;
`else
  localparam logic [7:0] EPS = 8'd26;
`endif

  logic           clk, rst, start;
  logic [5:0]     maze_state;
  logic [3:0]     blocked_mask;
  logic           q_rd_en;
  logic [5:0]     q_rd_state;
  logic [1:0]     q_rd_action;
  logic [Q_W-1:0] q_rd_data;
  logic [3:0]     action;
  logic           action_valid, no_legal, busy;

  typedef struct packed { logic [3:0] act; logic nl; } exp_t;
  exp_t sb[$];

  logic signed [Q_W-1:0] qv [4];
  int n_checks, n_fail;

  q_action_select #(.Q_W(Q_W), .EPS_THRESH(EPS)) dut (
    .clk(clk), .rst(rst), .start(start), .maze_state(maze_state),
    .blocked_mask(blocked_mask), .q_rd_en(q_rd_en), .q_rd_state(q_rd_state),
    .q_rd_action(q_rd_action), .q_rd_data(q_rd_data), .action(action),
    .action_valid(action_valid), .no_legal(no_legal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Q-table read port: one-cycle latency
  always @(posedge clk) if (q_rd_en) q_rd_data <= qv[q_rd_action];

  function automatic logic [3:0] legal_mask(input int s, input logic [3:0] m);
    logic [3:0] lg;
    int row, col;
    row = (s - 1) / 6;
    col = (s - 1) % 6;
    lg[0] = row < 5;
    lg[1] = col < 5;
    lg[2] = row > 0;
    lg[3] = col > 0;
    return lg & ~m;
  endfunction

  function automatic exp_t model(input int s, input logic [3:0] m);
    exp_t e;
    logic [3:0] lg;
    int bi;
    e.act = 4'hF;
    e.nl  = 1'b1;
    if (s < 1 || s > 36) return e;
    lg = legal_mask(s, m);
    bi = -1;
    for (int a = 0; a < 4; a++)
      if (lg[a] && (bi < 0 || qv[a] > qv[bi])) bi = a;
    if (bi >= 0) begin
      e.act = 4'(bi);
      e.nl  = 1'b0;
    end
    return e;
  endfunction

  task automatic start_sel(input logic [5:0] s, input logic [3:0] m);
    @(negedge clk);
    maze_state   = s;
    blocked_mask = m;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    maze_state   = 6'($urandom);
    blocked_mask = 4'($urandom);
  endtask

  // Observes cycles T+1.. after an accept edge until action_valid (bounded), then one more cycle.
  task automatic collect(output int lat, output logic [31:0] rdm, output logic [31:0] bzm,
                         output logic [7:0] rseq, output logic [5:0] rdst,
                         output logic [3:0] act, output logic nl, output logic after);
    lat = 0; rdm = 0; bzm = 0; rseq = 0; rdst = 0; act = 0; nl = 0; after = 0;
    for (int n = 1; n <= 20; n++) begin
      if (q_rd_en) begin
        rdm[n] = 1'b1;
        rseq   = {rseq[5:0], q_rd_action};
        rdst   = q_rd_state;
      end
      bzm[n] = busy;
      if (action_valid) begin
        lat = n;
        act = action;
        nl  = no_legal;
        @(posedge clk);
        #1;
        after = action_valid;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (action !== 4'hF) begin n_fail++; $display("FAIL reset_action got=%0h exp=f", action); end
    n_checks++; if (action_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", action_valid); end
    n_checks++; if (no_legal !== 1'b0) begin n_fail++; $display("FAIL reset_no_legal got=%0b exp=0", no_legal); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (q_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%0b exp=0", q_rd_en); end
    n_checks++; if (q_rd_state !== 6'd0) begin n_fail++; $display("FAIL reset_rd_state got=%0d exp=0", q_rd_state); end
    n_checks++; if (q_rd_action !== 2'd0) begin n_fail++; $display("FAIL reset_rd_action got=%0d exp=0", q_rd_action); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_tie();
    exp_t e; int lat; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act; logic nl, after;
    qv[0] = 5; qv[1] = 9; qv[2] = 9; qv[3] = -3;
    sb.push_back('{act: 4'd1, nl: 1'b0});
    start_sel(6'd8, 4'd0);
    collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
    e = sb.pop_front();
    n_checks++; if (act !== e.act) begin n_fail++; $display("FAIL tie_action got=%0h exp=%0h", act, e.act); end
    n_checks++; if (nl !== e.nl) begin n_fail++; $display("FAIL tie_no_legal got=%0b exp=%0b", nl, e.nl); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL tie_latency got=%0d exp=6", lat); end
    n_checks++; if (rdm !== 32'h1E) begin n_fail++; $display("FAIL tie_rd_cycles got=%h exp=0000001e", rdm); end
    n_checks++; if (rseq !== 8'h1B) begin n_fail++; $display("FAIL tie_rd_order got=%h exp=1b", rseq); end
    n_checks++; if (rdst !== 6'd8) begin n_fail++; $display("FAIL tie_rd_state got=%0d exp=8", rdst); end
    n_checks++; if (bzm !== 32'h7E) begin n_fail++; $display("FAIL tie_busy got=%h exp=0000007e", bzm); end
    n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL tie_pulse_width got=%0b exp=0", after); end
  endtask

  task automatic test_corner();
    exp_t e; int lat; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act; logic nl, after;
    qv[0] = -10; qv[1] = -20; qv[2] = 100; qv[3] = 100;
    sb.push_back('{act: 4'd0, nl: 1'b0});
    start_sel(6'd1, 4'd0);
    collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
    e = sb.pop_front();
    n_checks++; if (act !== e.act) begin n_fail++; $display("FAIL corner_action got=%0h exp=%0h", act, e.act); end
    n_checks++; if (nl !== e.nl) begin n_fail++; $display("FAIL corner_no_legal got=%0b exp=%0b", nl, e.nl); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL corner_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_signed();
    exp_t e; int lat; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act; logic nl, after;
    qv[0] = -100; qv[1] = 32'sh8000_0000; qv[2] = -1; qv[3] = -50;
    sb.push_back('{act: 4'd2, nl: 1'b0});
    start_sel(6'd15, 4'd0);
    collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
    e = sb.pop_front();
    n_checks++; if (act !== e.act) begin n_fail++; $display("FAIL signed_action got=%0h exp=%0h", act, e.act); end
    n_checks++; if (nl !== e.nl) begin n_fail++; $display("FAIL signed_no_legal got=%0b exp=%0b", nl, e.nl); end
  endtask

  task automatic test_all_blocked();
    exp_t e; int lat; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act; logic nl, after;
    qv[0] = 1; qv[1] = 2; qv[2] = 3; qv[3] = 4;
    sb.push_back('{act: 4'hF, nl: 1'b1});
    start_sel(6'd36, 4'b1100);
    collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
    e = sb.pop_front();
    n_checks++; if (act !== e.act) begin n_fail++; $display("FAIL blocked_action got=%0h exp=%0h", act, e.act); end
    n_checks++; if (nl !== e.nl) begin n_fail++; $display("FAIL blocked_no_legal got=%0b exp=%0b", nl, e.nl); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL blocked_latency got=%0d exp=6", lat); end
    n_checks++; if (rdm !== 32'h1E) begin n_fail++; $display("FAIL blocked_rd_cycles got=%h exp=0000001e", rdm); end
  endtask

  task automatic test_err();
    exp_t e; int lat, stray; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act; logic nl, after;
    logic [5:0] bad [2];
    bad[0] = 6'd0; bad[1] = 6'd40;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{act: 4'hF, nl: 1'b1});
      start_sel(bad[i], 4'd0);
      collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
      stray = 0;
      for (int c = 0; c < 4; c++) begin
        if (q_rd_en) stray++;
        @(posedge clk);
        #1;
      end
      e = sb.pop_front();
      n_checks++; if (act !== e.act) begin n_fail++; $display("FAIL err_action s=%0d got=%0h exp=%0h", bad[i], act, e.act); end
      n_checks++; if (nl !== e.nl) begin n_fail++; $display("FAIL err_no_legal s=%0d got=%0b exp=%0b", bad[i], nl, e.nl); end
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL err_latency s=%0d got=%0d exp=1", bad[i], lat); end
      n_checks++; if (rdm !== 32'h0 || stray !== 0) begin n_fail++; $display("FAIL err_no_reads s=%0d got=%h/%0d exp=0/0", bad[i], rdm, stray); end
      n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width s=%0d got=%0b exp=0", bad[i], after); end
    end
  endtask

  task automatic test_random();
    exp_t e; int lat, t, s, xl; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act, m; logic nl, after;
    for (int it = 0; it < 40; it++) begin
      s = ($urandom_range(0, 7) == 0) ? ((it % 2 == 0) ? 0 : $urandom_range(37, 63)) : $urandom_range(1, 36);
      m = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      for (int a = 0; a < 4; a++) begin
        case ($urandom_range(0, 3))
          0: begin t = $urandom_range(0, 4); qv[a] = t - 2; end
          1: qv[a] = $urandom;
          2: qv[a] = 32'sh8000_0000;
          default: qv[a] = 32'sh7FFF_FFFF;
        endcase
      end
      sb.push_back(model(s, m));
      xl = (s < 1 || s > 36) ? 1 : 6;
      start_sel(6'(s), m);
      collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
      e = sb.pop_front();
      n_checks++; if (act !== e.act) begin n_fail++; $display("FAIL rand_action it=%0d s=%0d got=%0h exp=%0h", it, s, act, e.act); end
      n_checks++; if (nl !== e.nl) begin n_fail++; $display("FAIL rand_no_legal it=%0d s=%0d got=%0b exp=%0b", it, s, nl, e.nl); end
      n_checks++; if (lat !== xl) begin n_fail++; $display("FAIL rand_latency it=%0d s=%0d got=%0d exp=%0d", it, s, lat, xl); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int pulses, xc;
    qv[0] = 3; qv[1] = 1; qv[2] = 4; qv[3] = 1;
    sb.push_back(model(8, 4'd0));
    sb.push_back(model(8, 4'd0));
    pulses = 0;
    @(negedge clk);
    maze_state = 6'd8; blocked_mask = 4'd0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 13) start = 1'b0;
      if (action_valid) begin
        pulses++;
        xc = (pulses == 1) ? 5 : 12;
        n_checks++; if (c !== xc) begin n_fail++; $display("FAIL b2b_pulse_cycle n=%0d got=%0d exp=%0d", pulses, c, xc); end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_result got=%0h exp=none", action);
        end else begin
          e = sb.pop_front();
          if (action !== e.act) begin n_fail++; $display("FAIL b2b_action n=%0d got=%0h exp=%0h", pulses, action, e.act); end
        end
      end
    end
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act; logic nl, after;
    qv[0] = 7; qv[1] = 8; qv[2] = 9; qv[3] = 10;
    start_sel(6'd8, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (q_rd_en !== 1'b1) begin n_fail++; $display("FAIL rmid_scan_active got=%0b exp=1", q_rd_en); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (q_rd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_rd_en got=%0b exp=0", q_rd_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    n_checks++; if (action !== 4'hF) begin n_fail++; $display("FAIL rmid_action got=%0h exp=f", action); end
    n_checks++; if (action_valid !== 1'b0 || no_legal !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got=%0b%0b exp=00", action_valid, no_legal); end
    n_checks++; if (q_rd_state !== 6'd0 || q_rd_action !== 2'd0) begin n_fail++; $display("FAIL rmid_rd_addr got=%0d/%0d exp=0/0", q_rd_state, q_rd_action); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    qv[0] = -4; qv[1] = 12; qv[2] = 6; qv[3] = 12;
    sb.push_back(model(22, 4'd0));
    maze_state = 6'd22; blocked_mask = 4'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
    e = sb.pop_front();
    n_checks++; if (act !== e.act || nl !== e.nl) begin n_fail++; $display("FAIL rmid_after_action got=%0h/%0b exp=%0h/%0b", act, nl, e.act, e.nl); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rmid_after_latency got=%0d exp=6", lat); end
    n_checks++; if (rdm !== 32'h1E) begin n_fail++; $display("FAIL rmid_after_rd_cycles got=%h exp=0000001e", rdm); end
  endtask

`ifdef Q_SEL_EPSILON_EN
  task automatic test_eps_legal();
    int lat, s; logic [31:0] rdm, bzm; logic [7:0] rseq; logic [5:0] rdst; logic [3:0] act, m, lg; logic nl, after, ok;
    for (int it = 0; it < 1000; it++) begin
      s = $urandom_range(1, 36);
      m = 4'($urandom_range(0, 15));
      for (int a = 0; a < 4; a++) qv[a] = $urandom;
      lg = legal_mask(s, m);
      start_sel(6'(s), m);
      collect(lat, rdm, bzm, rseq, rdst, act, nl, after);
      ok = (lg == 4'd0) ? (act === 4'hF && nl === 1'b1)
                        : (act[3:2] === 2'b00 && lg[act[1:0]] === 1'b1 && nl === 1'b0);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL eps_legal it=%0d s=%0d legal=%b got=%0h/%0b", it, s, lg, act, nl); end
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL eps_latency it=%0d got=%0d exp=6", it, lat); end
    end
  endtask
`endif

  initial begin
    clk = 1'b0; rst = 1'b0; start = 1'b0; maze_state = 6'd0; blocked_mask = 4'd0;
    n_checks = 0; n_fail = 0;
    test_reset();
`ifndef Q_SEL_EPSILON_EN
    test_tie();
    test_corner();
    test_signed();
    test_random();
    test_back_to_back();
    test_reset_mid();
`endif
    test_all_blocked();
    test_err();
`ifdef Q_SEL_EPSILON_EN
    test_eps_legal();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q_action_select.md
# q_action_select

Greedy action selector for the Q-learning maze trial path. On each `start` it reads the four Q values of the current maze state from the Q-table read port and scans them one per cycle. It picks the highest signed value among the legal moves of the 6x6 grid, with states 1..36 in row-major order. It then presents the chosen action to the exploit stage, which turns it into `next_state`.

## Interface
Parameters:
- `Q_W`, 32: Q-value width, signed two's complement.
- `EPS_THRESH`, 8'd26: exploration threshold out of 256 (about 10%). Used only when `Q_SEL_EPSILON_EN` is defined.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one selection; sampled only in IDLE.
- `maze_state`  in  6  current state; legal values 1..36.
- `blocked_mask`  in  4  bit a=1 excludes action a (wall/blocked cell); sampled with `start`.
- `q_rd_en`  out  1  Q-table read strobe.
- `q_rd_state`  out  6  Q-table row address.
- `q_rd_action`  out  2  Q-table column address.
- `q_rd_data`  in  Q_W  read data, valid exactly 1 cycle after `q_rd_en`.
- `action`  out  4  chosen action: 0=+6 (down), 1=+1 (right), 2=-6 (up), 3=-1 (left), 4'hF=no move.
- `action_valid`  out  1  one-cycle pulse when `action` is updated.
- `no_legal`  out  1  set with `action_valid` when every action was excluded.
- `busy`  out  1  high from the cycle after `start` accept up to and including the DONE cycle.

## Operation
- States: IDLE, SCAN, DRAIN, DONE, ERR.
- IDLE, `start`=1:
  - Latch `maze_state` as `s` and compute the legal mask.
  - If `s`==0 or `s`>36, go to ERR.
  - Otherwise go to SCAN with k=0.
- Legal mask: action a is legal when `blocked_mask[a]`=0 and:
  - a0: s+6<=36.
  - a1: s mod 6 != 0 (not right column).
  - a2: s>=7.
  - a3: s mod 6 != 1 (not left column).
- SCAN, k=0..3:
  - Drive `q_rd_en`=1, `q_rd_state`=s, `q_rd_action`=k.
  - Compare the data returned for k-1 (for k>=1).
  - After k=3, go to DRAIN, which compares the k=3 data.
  - Reads are issued for every action, masked or not, so latency is fixed.
- Compare rule:
  - Signed compare at full Q_W width; no saturation or truncation.
  - The first legal action seeds `best`.
  - A later legal action replaces `best` only if its value is strictly greater, so ties go to the lowest index.
  - Illegal actions are ignored.
- DONE:
  - Drive `action` = best index (or 4'hF with `no_legal`=1 if none was legal).
  - Pulse `action_valid` and return to IDLE.
- ERR:
  - `action`=4'hF, `no_legal`=1, `action_valid` pulsed for 1 cycle, then back to IDLE.
- `action` and `no_legal` hold their values until the next DONE or ERR.
- `start` while not in IDLE is ignored; it is not queued.

## Timing
- Reset values (asynchronous, on `rst`=0): state IDLE, `action`=4'hF, `action_valid`=0, `no_legal`=0, `busy`=0, `q_rd_en`=0, `q_rd_state`=0, `q_rd_action`=0, best register cleared.
- `start` accepted on edge T:
  - `q_rd_en` high in cycles T+1..T+4, with actions 0..3.
  - Data for each read arrives in cycles T+2..T+5.
  - DRAIN is cycle T+5.
  - DONE and the `action_valid` pulse are in cycle T+6.
  - Next `start` is accepted at T+7 at the earliest.
- ERR path: `action_valid` in cycle T+1; no reads are issued.
- Reset asserted mid-scan:
  - Immediately returns to IDLE, drops `q_rd_en`, and suppresses `action_valid`.
  - The pending read data is discarded.
- `maze_state` and `blocked_mask` may change freely after the accept edge; only the latched copies are used.

## Configuration
- `Q_SEL_EPSILON_EN` defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every cycle.
  - At DONE, if `lfsr[7:0]` < `EPS_THRESH` and at least one action is legal, `action` = the first legal action at or after index `lfsr[9:8]`, wrapping 3->0, instead of the argmax.
  - Timing is unchanged.
- Not defined: no LFSR; the block is purely greedy and deterministic.

## Test plan
- s=8, mask 0, Q={5,9,9,-3} -> read strobes at T+1..T+4; `action`=1 at T+6 (tie goes to the lower index); `no_legal`=0.
- s=1 (top-left corner), Q={-10,-20,100,100} -> actions 2 and 3 are illegal, so `action`=0.
- s=36, `blocked_mask`=4'b1100 -> all actions excluded; `action`=4'hF, `no_legal`=1, `action_valid` at T+6.
- s=0 and s=40 -> ERR path; `action`=4'hF, `no_legal`=1 at T+1; `q_rd_en` never asserted.
- Negative values: s=15, Q={-100, 32'h8000_0000, -1, -50} -> `action`=2 (signed compare).
- Drop `rst` at T+3 of a scan -> all outputs at reset values immediately; no `action_valid`; `start` at the first edge after release behaves normally. With `Q_SEL_EPSILON_EN` defined and `EPS_THRESH`=255, the chosen action is always legal over 1000 starts.
